// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multicycle MIPS memory responder.
// Holds the FSM state encoding, latency counter width and word/alignment geometry.
package mc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } memState;

  localparam int LAT_W      = 4;
  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  // Counter preload: a latency of N cycles counts N-1 down to 0.
  function automatic logic [LAT_W-1:0] latLoad(input int lat);
    return LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mc_mem_array.sv
// Word-addressed storage behind the responder: synchronous write, combinational read.
// No reset on the contents; the responder decides when a write is committed.
module mc_mem_array
  import mc_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wrData,
  output logic [WORD_W-1:0]              rdData
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wrData;
    end
  end

  assign rdData = mem[idx];

endmodule

// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory responder with fixed read/write wait states.
// Latches one request, counts down its latency, then pulses MemReady (and AddrErr on a bad request).
module mc_mem_responder
  import mc_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    RD_LAT      = 2,
  parameter int    WR_LAT      = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        AddrErr,
  output memState     dbgState
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  memState           state;
  memState           stateNext;
  logic [LAT_W-1:0]  latCnt;
  logic [IDX_W-1:0]  idxLat;
  logic [WORD_W-1:0] wrDataLat;
  logic [WORD_W-1:0] arrayRdData;
  logic              errLat;
  logic              reqRead;
  logic              accept;
  logic              cntZero;
  logic              memWe;
  logic              rdLoad;
  logic              unusedAddrHi;

  // Both strobes together is not a read; it rides the write path as a no-op.
  assign reqRead = MemRd & ~MemWr;
  assign accept  = (state == IDLE) & (MemRd | MemWr);
  assign cntZero = (latCnt == '0);

  // Upper address bits alias the array; they are intentionally dropped.
  assign unusedAddrHi = &{1'b0, Addr[WORD_W-1:IDX_W+BYTE_OFF_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (reqRead) begin
          stateNext = RD_WAIT;
        end else if (MemWr) begin
          stateNext = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cntZero) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    memWe  = 1'b0;
    rdLoad = 1'b0;
    case (state)
      RD_WAIT: rdLoad = cntZero;
      WR_WAIT: memWe  = cntZero & ~errLat;
      default: begin
        memWe  = 1'b0;
        rdLoad = 1'b0;
      end
    endcase
  end

  // Request latch, latency counter and registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latCnt    <= '0;
      idxLat    <= '0;
      wrDataLat <= '0;
      errLat    <= 1'b0;
      MemBusy   <= 1'b0;
      MemReady  <= 1'b0;
      AddrErr   <= 1'b0;
      RdData    <= '0;
    end else begin
      MemReady <= 1'b0;
      AddrErr  <= 1'b0;
      if (accept) begin
        latCnt    <= reqRead ? latLoad(RD_LAT) : latLoad(WR_LAT);
        idxLat    <= Addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
        wrDataLat <= WrData;
        errLat    <= (Addr[BYTE_OFF_W-1:0] != '0) | (MemRd & MemWr);
        MemBusy   <= 1'b1;
      end else if (state != IDLE) begin
        if (cntZero) begin
          MemBusy  <= 1'b0;
          MemReady <= 1'b1;
          AddrErr  <= errLat;
        end else begin
          latCnt <= latCnt - 1'b1;
        end
      end
      if (rdLoad) begin
        RdData <= errLat ? '0 : arrayRdData;
      end
    end
  end

  mc_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .we     (memWe),
    .idx    (idxLat),
    .wrData (wrDataLat),
    .rdData (arrayRdData)
  );

  assign dbgState = state;

endmodule
